// File: rtl/irq_controller_pkg.sv
// rtl/irq_controller_pkg.sv - vectors and FSM encodings shared with the interrupt sequencer
package irq_controller_pkg;

  localparam logic [31:0] VECTOR_RESET    = 32'h0000_0000;
  localparam logic [31:0] VECTOR_SYSCALL  = 32'h0000_0004;
  localparam logic [31:0] VECTOR_IRQ_BASE = 32'h0000_0008;

  localparam int ID_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - three-flop synchronizer with rising-edge pulse for one IRQ line
module irq_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic irq_in,
  output logic edge_pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched IRQ pending/mask with lowest-index, non-nesting req/ack to the sequencer
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int          NUM_IRQ         = 8,
  parameter logic [31:0] VECTOR_IRQ_BASE = irq_controller_pkg::VECTOR_IRQ_BASE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_system,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               gie,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               syscall_pending,
  input  logic               it_ack,
  input  logic               it_done,
  output logic               it_req,
  output logic [31:0]        it_vector,
  output logic [ID_W-1:0]    it_id,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [NUM_IRQ-1:0] irq_mask,
  output logic               irq_busy
);

  irq_state_e         state, state_next;
  logic [NUM_IRQ-1:0] edge_vec, eligible, clear_vec;
  logic [ID_W-1:0]    sel_id;
  logic               sel_valid, load, accept;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clock      (clock),
      .reset      (reset),
      .irq_in     (irq_in[g]),
      .edge_pulse (edge_vec[g])
    );
  end

  assign eligible  = irq_pending & irq_mask;
  assign sel_valid = |eligible;

  // Scan downwards so the lowest set index is the one left standing.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = ID_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    accept     = 1'b0;
    if (enable_system) begin
      case (state)
        ST_IDLE: begin
          if (gie && sel_valid && !syscall_pending) begin
            state_next = ST_REQ;
            load       = 1'b1;
          end
        end
        ST_REQ: begin
          if (it_ack) begin
            state_next = ST_SERVICE;
            accept     = 1'b1;
          end
        end
        ST_SERVICE: begin
          if (it_done) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign clear_vec = accept ? (NUM_IRQ'(1) << it_id) : '0;

  // A new edge in the ack cycle is OR-ed in after the clear, so it survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_pending <= '0;
      irq_mask    <= '0;
      it_id       <= '0;
      it_vector   <= '0;
    end else begin
      irq_pending <= (irq_pending & ~clear_vec) | edge_vec;
      if (mask_we) irq_mask <= mask_wdata;
      if (load) begin
        it_id     <= sel_id;
        it_vector <= VECTOR_IRQ_BASE + {26'd0, sel_id, 2'b00};
      end
    end
  end

  assign it_req   = (state == ST_REQ);
  assign irq_busy = (state != ST_IDLE);

endmodule

// File: doc/irq_controller.md
# irq_controller

External interrupt request controller sitting directly upstream of the CPU interrupt sequencer. It synchronizes peripheral IRQ lines, latches rising edges into a pending register, applies a software mask and global enable, and selects the lowest-numbered eligible line. It then hands the sequencer one request at a time, with a vector address, over a req/ack handshake. No new request is issued until the sequencer reports completion of the return sequence, so interrupts do not nest.

## Interface
- NUM_IRQ, 8, number of external IRQ lines (1..16)
- VECTOR_IRQ_BASE, 32'h0000_0008, vector of line 0; line i vector = base + 4*i
- clock  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high
- enable_system  input  1  arbitration FSM advances only when 1
- irq_in  input  NUM_IRQ  asynchronous level lines from peripherals, rising edge = event
- gie  input  1  global interrupt enable
- mask_we  input  1  write strobe for mask register
- mask_wdata  input  NUM_IRQ  new mask (1 = line enabled)
- syscall_pending  input  1  syscall request this cycle; blocks new IRQ selection
- it_ack  input  1  sequencer accepted request (entered save sequence)
- it_done  input  1  sequencer finished return sequence (one-cycle pulse)
- it_req  output  1  request to sequencer, held until it_ack
- it_vector  output  32  vector for the request, stable while it_req=1
- it_id  output  4  index of the line being requested or serviced
- irq_pending  output  NUM_IRQ  pending register
- irq_mask  output  NUM_IRQ  mask register
- irq_busy  output  1  FSM not IDLE

## Operation
- Per line: 3-flop chain s1→s2→s3. Event = s2 & ~s3. Event sets pending[i]. The chain and pending capture run regardless of enable_system, so no edge is lost.
- Pending is a flag, not a counter. Repeated edges while pending stay 1.
- eligible = pending & mask. Selection is the lowest set index.
- Mask: on mask_we, mask <= mask_wdata.
- FSM states:
  - IDLE → REQ when enable_system & gie & |eligible & ~syscall_pending. On that edge, latch it_id = selected index and it_vector = VECTOR_IRQ_BASE + {id,2'b00}.
  - REQ: it_req=1. → SERVICE on it_ack; clear pending[it_id] on the same edge. Mask or gie changes while in REQ do not withdraw the request.
  - SERVICE: → IDLE on it_done. it_id is held.
- Simultaneous set and clear of pending[it_id] (new edge in the ack cycle): set wins, pending stays 1.
- it_done in REQ or IDLE: ignored. it_ack outside REQ: ignored.
- Reset at any point, including mid-REQ or mid-SERVICE: returns to IDLE with all state at reset values. An in-flight request is dropped.

## Timing
- Reset values: it_req=0, it_vector=0, it_id=0, irq_pending=0, irq_mask=0, irq_busy=0, sync flops=0.
- irq_in rises before posedge N → s1=1 after N, s2=1 after N+1, pending=1 after N+2. it_req=1 after N+3, provided eligible and IDLE with enable_system=1.
- it_req, it_vector and it_id are registered; no combinational path from inputs to them.
- it_ack sampled at posedge K → it_req=0 and pending cleared after K.
- it_done at posedge D → IDLE after D. The earliest next it_req is after D+1.
- enable_system=0: FSM, it_req and it_vector hold; mask writes still apply.

## Structure
- Shared header: VECTOR_RESET, VECTOR_SYSCALL, VECTOR_IRQ_BASE defines and the FSM state encodings (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2). These are shared with the interrupt sequencer.
- Sub-module irq_sync_edge: one line's 3-flop synchronizer plus rising-edge pulse, instantiated NUM_IRQ times via generate.
- Priority encoder and FSM live in irq_controller.

## Test plan
- Reset, mask=8'h04, gie=1, pulse irq_in[2] → it_req=1 four cycles after the edge, it_vector=32'h10, it_id=2. it_ack → pending[2]=0, it_req=0.
- mask=8'hFF, irq_in[5] and irq_in[1] rise together → line 1 served first (vector 32'h0C). After it_done, line 5 is served (vector 32'h1C) starting on the cycle after it_done.
- mask=0, pulse irq_in[3], then write mask=8'h08 → pending[3] already 1, request follows on the next IDLE cycle.
- syscall_pending=1 for 5 cycles with eligible IRQ → no it_req until syscall_pending drops.
- New edge on line 2 landing in the it_ack cycle for line 2 → pending[2] remains 1, re-request after it_done.
- Assert reset during SERVICE → irq_busy=0, irq_pending=0, irq_mask=0, it_req=0 next cycle.
